// File: rtl/layer_ctrl_pkg.sv
// Shared types for the fully-connected layer controller: FSM state encoding
// and a width helper for the modulo counters.
package layer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_WRITE,
        ST_OUTPUT
    } layer_ctrl_state_t;

    // A modulus of 1 still needs a one-bit register
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

endpackage

// File: rtl/layer_ctrl_counter.sv
// Modulo-MOD up counter with synchronous clear and a terminal-count flag;
// used for the input index n and the output row m.
module layer_ctrl_counter
    import layer_ctrl_pkg::*;
#(
    parameter int MOD = 8,
    localparam int W = cnt_width(MOD)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         last
);

    assign last = (count == W'(MOD - 1));

    // Clear has priority over increment; increment wraps at the terminal value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/layer_ctrl.sv
// Controller for one fully-connected layer (P=1): loads an N-word input vector,
// then sequences weight/input reads, MAC accumulation and output of M rows.
module layer_ctrl
    import layer_ctrl_pkg::*;
#(
    parameter int M  = 10,
    parameter int N  = 8,
    parameter int XW = $clog2(N),
    parameter int WW = $clog2(M * N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [XW-1:0] x_addr,
    output logic          x_wr_en,
    output logic [WW-1:0] w_addr,
    output logic          acc_en,
    output logic          acc_clr,
    output logic          out_ld
);

    localparam int MW = cnt_width(M);

    layer_ctrl_state_t state;

    logic          s_hs;
    logic          m_hs;
    logic          n_inc;
    logic          n_clr;
    logic          n_last;
    logic          m_inc;
    logic          m_clr;
    logic          m_last;
    logic [XW-1:0] n_count;
    logic [MW-1:0] m_count;
    logic          unused_m;

    assign s_hs    = s_valid && s_ready;
    assign m_hs    = m_valid && m_ready;
    assign x_wr_en = s_hs;
    assign x_addr  = n_count;

    // The same n counter serves as write address in LOAD and read address in COMPUTE
    assign n_inc = s_hs || (state == ST_COMPUTE);
    assign n_clr = (s_hs && n_last) || m_hs;
    assign m_inc = m_hs && !m_last;
    assign m_clr = (s_hs && n_last) || (m_hs && m_last);

    assign unused_m = ^m_count;

    layer_ctrl_counter #(.MOD(N)) u_n_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (n_clr),
        .inc   (n_inc),
        .count (n_count),
        .last  (n_last)
    );

    layer_ctrl_counter #(.MOD(M)) u_m_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (m_clr),
        .inc   (m_inc),
        .count (m_count),
        .last  (m_last)
    );

    // acc_en/acc_clr trail the issue cycle by one to match the 1-cycle memory read;
    // w_addr keeps running across rows so it tracks m*N+n without a multiplier
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            acc_en  <= 1'b0;
            acc_clr <= 1'b0;
            out_ld  <= 1'b0;
            w_addr  <= '0;
        end else begin
            acc_en  <= (state == ST_COMPUTE);
            acc_clr <= (state == ST_COMPUTE) && (n_count == '0);
            out_ld  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state   <= ST_LOAD;
                    s_ready <= 1'b1;
                end
                ST_LOAD: begin
                    if (s_hs && n_last) begin
                        state   <= ST_COMPUTE;
                        s_ready <= 1'b0;
                        w_addr  <= '0;
                    end
                end
                ST_COMPUTE: begin
                    w_addr <= w_addr + 1'b1;
                    if (n_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state  <= ST_WRITE;
                    out_ld <= 1'b1;
                end
                ST_WRITE: begin
                    state   <= ST_OUTPUT;
                    m_valid <= 1'b1;
                end
                ST_OUTPUT: begin
                    if (m_hs) begin
                        m_valid <= 1'b0;
                        if (m_last) begin
                            state   <= ST_LOAD;
                            s_ready <= 1'b1;
                            w_addr  <= '0;
                        end else begin
                            state <= ST_COMPUTE;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    s_ready <= 1'b0;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
